cic_decimate: RTL

//  N-stage CIC decimator, rate-change factor R, differential delay M=1. Mirror of the

---
 rtl/cic_defs_pkg.sv | 20 ++
 rtl/cic_comb_stage.sv | 30 +++
 rtl/cic_decimate.sv | 87 ++++++++
 3 files changed

// File: rtl/cic_defs_pkg.sv
// Shared CIC helpers: ceil-log2 and full-precision register width.
// Used by both the decimator and the interpolator.
package cic_defs_pkg;

   function automatic int unsigned cic_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Bit growth of an N-stage, M=1 CIC is N*log2(R).
   function automatic int unsigned cic_gw(input int unsigned din_w, input int unsigned n,
                                          input int unsigned r);
      return din_w + n * cic_clog2(r);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage (M=1): on en, y = x - x_prev and x_prev takes x.
// The valid bit is registered alongside the data.
module cic_comb_stage #(
   parameter int unsigned W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         vout
);

   logic [W-1:0] x_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y      <= '0;
         x_prev <= '0;
         vout   <= 1'b0;
      end else begin
         vout <= en;
         if (en) begin
            y      <= x - x_prev;
            x_prev <= x;
         end
      end
   end

endmodule

// File: rtl/cic_decimate.sv
// N-stage CIC decimator by R (M=1), full-precision integrators with modular wrap,
// comb chain clocked by the registered decimation strobe, MSB-truncated output.
module cic_decimate
   import cic_defs_pkg::*;
#(
   parameter int unsigned DIN_W  = 8,
   parameter int unsigned N      = 3,
   parameter int unsigned R      = 4,
   parameter int unsigned DOUT_W = 14
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic [DIN_W-1:0]  data_in,
   input  logic              data_v,
   output logic [DOUT_W-1:0] data_out,
   output logic              data_ov
);

   localparam int unsigned GW = cic_gw(DIN_W, N, R);
   localparam int unsigned CW = cic_clog2(R);

   logic [CW-1:0] cnt_q;
   logic          dec;
   logic          dec_q;
   logic [GW-1:0] integ_q [N];
   logic [GW-1:0] integ_d [N];
   logic [GW-1:0] comb_x  [N+1];
   logic [N:0]    comb_v;

   assign dec = data_v && (cnt_q == CW'(R - 1));

   // Each stage adds the already-updated previous stage, so the last integrator
   // register holds the exact cascade sum including the sample just taken.
   always_comb begin
      logic [GW-1:0] acc;
      acc = GW'($signed(data_in));
      for (int k = 0; k < int'(N); k++) begin
         acc        = integ_q[k] + acc;
         integ_d[k] = acc;
      end
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         dec_q <= 1'b0;
         for (int k = 0; k < int'(N); k++) begin
            integ_q[k] <= '0;
         end
      end else begin
         dec_q <= dec;
         if (data_v) begin
            cnt_q   <= cnt_q + CW'(1);
            integ_q <= integ_d;
         end
      end
   end

   assign comb_x[0] = integ_q[N-1];
   assign comb_v[0] = dec_q;

   for (genvar k = 0; k < int'(N); k++) begin : g_comb
      cic_comb_stage #(
         .W (GW)
      ) u_comb (
         .clk  (sclk),
         .rst  (rst),
         .en   (comb_v[k]),
         .x    (comb_x[k]),
         .y    (comb_x[k+1]),
         .vout (comb_v[k+1])
      );
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         data_ov  <= 1'b0;
      end else begin
         data_ov <= comb_v[N];
         if (comb_v[N]) begin
            data_out <= comb_x[N][GW-1 -: DOUT_W];
         end
      end
   end

endmodule
